param_dispatch: RTL and testbench

- Parametrised in-order dispatch stage for the tensor core. Generalises the fixed scalar/matrix/gemm dispatch to NUM_FU functional units and a NUM_REGS register result-status table (RST).
- Accepts one decoded instruction per cycle from fetch and stalls on structural or WAW hazards.
- Tags RAW source operands with the producing FU index.
- Adds single-level branch speculation: the RST is checkpointed when a branch dispatches, and on a mispredict the block restores the RST and kills wrong-path FUs.

---
 rtl/param_dispatch_if.sv | 48 ++++
 rtl/param_dispatch.sv | 164 ++++++++++++++++
 tb/tb_param_dispatch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/param_dispatch_if.sv
// Dispatch-stage bus: fetch request, issue/writeback feedback, branch resolution and dispatch outputs.
interface param_dispatch_if #(
    parameter int unsigned NUM_FU   = 5,
    parameter int unsigned NUM_REGS = 32
);
    localparam int unsigned FU_W  = $clog2(NUM_FU);
    localparam int unsigned REG_W = $clog2(NUM_REGS);

    logic              fetch_valid;
    logic [FU_W-1:0]   in_fu;
    logic [REG_W-1:0]  in_rd;
    logic              in_rd_en;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic              in_is_branch;
    logic [NUM_FU-1:0] fu_busy;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [FU_W-1:0]   wb_fu;
    logic              branch_resolved;
    logic              branch_miss;

    logic              fetch_ready;
    logic              freeze;
    logic              disp_valid;
    logic [FU_W-1:0]   disp_fu;
    logic [REG_W-1:0]  disp_rd;
    logic              disp_rd_en;
    logic [FU_W:0]     disp_t1;
    logic [FU_W:0]     disp_t2;
    logic              disp_spec;
    logic              flush;
    logic [NUM_FU-1:0] kill_mask;

    modport master (
        output fetch_valid, in_fu, in_rd, in_rd_en, in_rs1, in_rs2, in_is_branch,
               fu_busy, wb_valid, wb_rd, wb_fu, branch_resolved, branch_miss,
        input  fetch_ready, freeze, disp_valid, disp_fu, disp_rd, disp_rd_en,
               disp_t1, disp_t2, disp_spec, flush, kill_mask
    );

    modport slave (
        input  fetch_valid, in_fu, in_rd, in_rd_en, in_rs1, in_rs2, in_is_branch,
               fu_busy, wb_valid, wb_rd, wb_fu, branch_resolved, branch_miss,
        output fetch_ready, freeze, disp_valid, disp_fu, disp_rd, disp_rd_en,
               disp_t1, disp_t2, disp_spec, flush, kill_mask
    );
endinterface

// File: rtl/param_dispatch.sv
// In-order dispatch with structural/WAW stalls, RAW source tagging and
// single-level branch speculation backed by a checkpointed result-status table.
module param_dispatch #(
    parameter int unsigned NUM_FU   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          CLK,
    input  logic          RST,
    param_dispatch_if.slave i_disp
);
    localparam int unsigned FU_W  = $clog2(NUM_FU);
    localparam int unsigned REG_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {ST_NORMAL, ST_SPEC, ST_RECOVER} state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_REGS-1:0] r_pend, r_cp_pend;
    logic [FU_W-1:0]     r_tag    [NUM_REGS];
    logic [FU_W-1:0]     r_cp_tag [NUM_REGS];
    logic [NUM_FU-1:0]   r_spec_mask;

    logic              r_disp_valid, r_disp_rd_en, r_disp_spec, r_flush;
    logic [FU_W-1:0]   r_disp_fu;
    logic [REG_W-1:0]  r_disp_rd;
    logic [FU_W:0]     r_disp_t1, r_disp_t2;
    logic [NUM_FU-1:0] r_kill_mask;

    logic [NUM_REGS-1:0] w_pend_wb, w_cp_pend_wb, w_pend_nxt, w_cp_pend_nxt;
    logic [FU_W-1:0]     w_tag_nxt    [NUM_REGS];
    logic [FU_W-1:0]     w_cp_tag_nxt [NUM_REGS];
    logic [NUM_FU-1:0]   w_busy_eff, w_spec_mask_nxt;
    logic                w_stall, w_accept, w_miss, w_hit, w_rd_zero, w_spec_disp;
    logic [FU_W:0]       w_t1, w_t2;

    // Hazard detection, tag lookup, next table/checkpoint and FSM next-state.
    always_comb begin
        w_state_nxt     = r_state;
        w_busy_eff      = i_disp.fu_busy;
        w_pend_wb       = r_pend;
        w_cp_pend_wb    = r_cp_pend;
        w_tag_nxt       = r_tag;
        w_cp_tag_nxt    = r_cp_tag;
        w_spec_mask_nxt = r_spec_mask;
        w_rd_zero       = (ZERO_REG != 0) && (i_disp.in_rd == '0);

        if (r_disp_valid)
            w_busy_eff = w_busy_eff | (NUM_FU'(1) << r_disp_fu);

        // Writeback clears an entry only when the producer tag still matches.
        if (i_disp.wb_valid && r_pend[i_disp.wb_rd] && r_tag[i_disp.wb_rd] == i_disp.wb_fu)
            w_pend_wb[i_disp.wb_rd] = 1'b0;
        if (i_disp.wb_valid && r_cp_pend[i_disp.wb_rd] && r_cp_tag[i_disp.wb_rd] == i_disp.wb_fu)
            w_cp_pend_wb[i_disp.wb_rd] = 1'b0;

        w_miss  = (r_state == ST_SPEC) && i_disp.branch_resolved && i_disp.branch_miss;
        w_hit   = (r_state == ST_SPEC) && i_disp.branch_resolved && !i_disp.branch_miss;
        w_stall = (r_state == ST_RECOVER)
               || w_busy_eff[i_disp.in_fu]
               || (i_disp.in_rd_en && w_pend_wb[i_disp.in_rd] && !w_rd_zero)
               || (i_disp.in_is_branch && r_state == ST_SPEC && !i_disp.branch_resolved)
               || (i_disp.branch_resolved && i_disp.branch_miss);
        w_accept    = i_disp.fetch_valid && !w_stall;
        w_spec_disp = (r_state == ST_SPEC) && !i_disp.branch_resolved;

        w_t1 = {r_pend[i_disp.in_rs1], r_tag[i_disp.in_rs1]};
        if ((i_disp.wb_valid && i_disp.wb_rd == i_disp.in_rs1 && i_disp.wb_fu == r_tag[i_disp.in_rs1])
            || (ZERO_REG != 0 && i_disp.in_rs1 == '0))
            w_t1 = '0;
        w_t2 = {r_pend[i_disp.in_rs2], r_tag[i_disp.in_rs2]};
        if ((i_disp.wb_valid && i_disp.wb_rd == i_disp.in_rs2 && i_disp.wb_fu == r_tag[i_disp.in_rs2])
            || (ZERO_REG != 0 && i_disp.in_rs2 == '0))
            w_t2 = '0;

        w_pend_nxt    = w_pend_wb;
        w_cp_pend_nxt = w_cp_pend_wb;
        if (w_miss) begin
            w_pend_nxt = w_cp_pend_wb;
            w_tag_nxt  = r_cp_tag;
        end else if (w_accept && i_disp.in_rd_en && !w_rd_zero) begin
            w_pend_nxt[i_disp.in_rd] = 1'b1;
            w_tag_nxt[i_disp.in_rd]  = i_disp.in_fu;
        end

        // A dispatching branch snapshots the live table after this cycle's writeback.
        if (w_accept && i_disp.in_is_branch) begin
            w_cp_pend_nxt = w_pend_wb;
            w_cp_tag_nxt  = r_tag;
        end

        if (w_miss || w_hit)
            w_spec_mask_nxt = '0;
        else if (w_accept && w_spec_disp)
            w_spec_mask_nxt = r_spec_mask | (NUM_FU'(1) << i_disp.in_fu);

        case (r_state)
            ST_NORMAL:  if (w_accept && i_disp.in_is_branch) w_state_nxt = ST_SPEC;
            ST_SPEC: begin
                if (w_miss)
                    w_state_nxt = ST_RECOVER;
                else if (w_hit)
                    w_state_nxt = (w_accept && i_disp.in_is_branch) ? ST_SPEC : ST_NORMAL;
            end
            ST_RECOVER: w_state_nxt = ST_NORMAL;
            default:    w_state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_NORMAL;
        else     r_state <= w_state_nxt;
    end

    // Tables, speculation mask and registered dispatch outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend       <= '0;
            r_cp_pend    <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_tag[i]    <= '0;
                r_cp_tag[i] <= '0;
            end
            r_spec_mask  <= '0;
            r_disp_valid <= 1'b0;
            r_disp_fu    <= '0;
            r_disp_rd    <= '0;
            r_disp_rd_en <= 1'b0;
            r_disp_t1    <= '0;
            r_disp_t2    <= '0;
            r_disp_spec  <= 1'b0;
            r_flush      <= 1'b0;
            r_kill_mask  <= '0;
        end else begin
            r_pend       <= w_pend_nxt;
            r_cp_pend    <= w_cp_pend_nxt;
            r_tag        <= w_tag_nxt;
            r_cp_tag     <= w_cp_tag_nxt;
            r_spec_mask  <= w_spec_mask_nxt;
            r_disp_valid <= w_accept;
            if (w_accept) begin
                r_disp_fu    <= i_disp.in_fu;
                r_disp_rd    <= i_disp.in_rd;
                r_disp_rd_en <= i_disp.in_rd_en;
                r_disp_t1    <= w_t1;
                r_disp_t2    <= w_t2;
                r_disp_spec  <= w_spec_disp;
            end
            r_flush     <= w_miss;
            r_kill_mask <= w_miss ? r_spec_mask : '0;
        end
    end

    assign i_disp.fetch_ready = w_accept;
    assign i_disp.freeze      = i_disp.fetch_valid && !w_accept;
    assign i_disp.disp_valid  = r_disp_valid;
    assign i_disp.disp_fu     = r_disp_fu;
    assign i_disp.disp_rd     = r_disp_rd;
    assign i_disp.disp_rd_en  = r_disp_rd_en;
    assign i_disp.disp_t1     = r_disp_t1;
    assign i_disp.disp_t2     = r_disp_t2;
    assign i_disp.disp_spec   = r_disp_spec;
    assign i_disp.flush       = r_flush;
    assign i_disp.kill_mask   = r_kill_mask;
endmodule

// File: tb/tb_param_dispatch.sv
// Directed bench for param_dispatch: dispatch latency, busy/WAW stalls, RAW tags,
// branch speculation with hit and miss, and reset during speculation.
module tb_param_dispatch;
    localparam int unsigned NUM_FU   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned FU_W     = 3;
    localparam int unsigned REG_W    = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    param_dispatch_if #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS)) bus ();

    param_dispatch #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS), .ZERO_REG(1)) dut (
        .CLK    (clk),
        .RST    (rst),
        .i_disp (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input int fu, input int rd, input int rd_en,
                       input int rs1, input int rs2, input int br);
        bus.fetch_valid  = 1'b1;
        bus.in_fu        = FU_W'(fu);
        bus.in_rd        = REG_W'(rd);
        bus.in_rd_en     = 1'(rd_en);
        bus.in_rs1       = REG_W'(rs1);
        bus.in_rs2       = REG_W'(rs2);
        bus.in_is_branch = 1'(br);
    endtask

    task automatic nofetch();
        bus.fetch_valid  = 1'b0;
        bus.in_rd_en     = 1'b0;
        bus.in_is_branch = 1'b0;
    endtask

    task automatic wb(input int v, input int rd, input int fu);
        bus.wb_valid = 1'(v);
        bus.wb_rd    = REG_W'(rd);
        bus.wb_fu    = FU_W'(fu);
    endtask

    task automatic resolve(input int r, input int m);
        bus.branch_resolved = 1'(r);
        bus.branch_miss     = 1'(m);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.fu_busy = '0;
        nofetch();
        bus.in_fu = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        wb(0, 0, 0);
        resolve(0, 0);
        cyc(); cyc();
        check("rst_valid", 32'(bus.disp_valid), 0);
        check("rst_flush", 32'(bus.flush), 0);
        check("rst_kill",  32'(bus.kill_mask), 0);
        check("rst_ready", 32'(bus.fetch_ready), 0);
        rst = 1'b0;

        // First dispatch: fu0 rd3 <- r1,r2
        drv(0, 3, 1, 1, 2, 0);
        #1 check("add_ready", 32'(bus.fetch_ready), 1);
        cyc();
        check("add_valid", 32'(bus.disp_valid), 1);
        check("add_fu",    32'(bus.disp_fu), 0);
        check("add_rd",    32'(bus.disp_rd), 3);
        check("add_t1",    32'(bus.disp_t1), 0);
        check("add_t2",    32'(bus.disp_t2), 0);
        check("add_spec",  32'(bus.disp_spec), 0);

        // Back-to-back on fu0 is held one cycle by the self-busy view
        drv(0, 4, 1, 3, 0, 0);
        #1 check("b2b_freeze", 32'(bus.freeze), 1);
        cyc();
        check("b2b_hold_valid", 32'(bus.disp_valid), 0);
        #1 check("b2b_ready", 32'(bus.fetch_ready), 1);
        cyc();
        check("b2b_valid", 32'(bus.disp_valid), 1);
        check("b2b_rd",    32'(bus.disp_rd), 4);
        check("raw_t1",    32'(bus.disp_t1), 32'h8);
        check("zero_t2",   32'(bus.disp_t2), 0);

        // Same-cycle writeback of r3 bypasses the tag; r4 still pending on fu0
        drv(1, 0, 0, 3, 4, 0);
        wb(1, 3, 0);
        cyc();
        wb(0, 0, 0);
        check("wbbyp_t1", 32'(bus.disp_t1), 0);
        check("wbbyp_t2", 32'(bus.disp_t2), 32'h8);

        // WAW on r3: pending from fu0, new writer on fu2
        drv(0, 3, 1, 0, 0, 0);
        cyc();
        check("waw_setup_valid", 32'(bus.disp_valid), 1);
        drv(2, 3, 1, 0, 0, 0);
        #1 check("waw_freeze0", 32'(bus.freeze), 1);
        cyc();
        check("waw_hold_valid", 32'(bus.disp_valid), 0);
        #1 check("waw_freeze1", 32'(bus.freeze), 1);
        cyc();
        wb(1, 3, 0);
        #1 check("waw_ready_on_wb", 32'(bus.fetch_ready), 1);
        cyc();
        wb(0, 0, 0);
        check("waw_valid", 32'(bus.disp_valid), 1);
        check("waw_fu",    32'(bus.disp_fu), 2);

        // Stale writeback {3,0} must not clear the fu2 tag
        drv(3, 0, 0, 3, 0, 0);
        wb(1, 3, 0);
        cyc();
        wb(0, 0, 0);
        check("stale_t1_same", 32'(bus.disp_t1), 32'hA);
        drv(4, 0, 0, 3, 0, 0);
        cyc();
        check("stale_t1_after", 32'(bus.disp_t1), 32'hA);
        nofetch();
        cyc();

        // Branch, two speculative instructions, then mispredict
        drv(4, 0, 0, 0, 0, 1);
        cyc();
        check("br_valid", 32'(bus.disp_valid), 1);
        check("br_spec",  32'(bus.disp_spec), 0);
        drv(1, 5, 1, 0, 0, 0);
        cyc();
        check("spec1_spec", 32'(bus.disp_spec), 1);
        drv(2, 6, 1, 0, 0, 0);
        cyc();
        check("spec2_spec", 32'(bus.disp_spec), 1);
        drv(3, 7, 1, 5, 6, 0);
        resolve(1, 1);
        #1 check("miss_drop", 32'(bus.fetch_ready), 0);
        cyc();
        resolve(0, 0);
        check("miss_flush", 32'(bus.flush), 1);
        check("miss_kill",  32'(bus.kill_mask), 32'h6);
        check("miss_valid", 32'(bus.disp_valid), 0);
        #1 check("recover_freeze", 32'(bus.freeze), 1);
        cyc();
        check("recover_flush", 32'(bus.flush), 0);
        check("recover_kill",  32'(bus.kill_mask), 0);
        cyc();
        check("restore_valid", 32'(bus.disp_valid), 1);
        check("restore_t1",    32'(bus.disp_t1), 0);
        check("restore_t2",    32'(bus.disp_t2), 0);
        check("restore_spec",  32'(bus.disp_spec), 0);
        nofetch();
        cyc();

        // Second branch waits for the first; correct resolution releases it
        drv(4, 0, 0, 0, 0, 1);
        cyc();
        drv(0, 0, 0, 0, 0, 1);
        #1 check("br2_freeze", 32'(bus.freeze), 1);
        cyc();
        check("br2_hold_valid", 32'(bus.disp_valid), 0);
        resolve(1, 0);
        #1 check("br2_ready", 32'(bus.fetch_ready), 1);
        cyc();
        resolve(0, 0);
        check("br2_valid", 32'(bus.disp_valid), 1);
        check("br2_fu",    32'(bus.disp_fu), 0);
        check("br2_spec",  32'(bus.disp_spec), 0);
        check("hit_flush", 32'(bus.flush), 0);
        drv(1, 8, 1, 0, 0, 0);
        cyc();
        check("br2_shadow_spec", 32'(bus.disp_spec), 1);

        // Reset mid-speculation
        nofetch();
        rst = 1'b1;
        cyc();
        check("rst2_valid", 32'(bus.disp_valid), 0);
        check("rst2_spec",  32'(bus.disp_spec), 0);
        check("rst2_fu",    32'(bus.disp_fu), 0);
        check("rst2_rd",    32'(bus.disp_rd), 0);
        check("rst2_flush", 32'(bus.flush), 0);
        rst = 1'b0;
        drv(2, 9, 1, 8, 7, 0);
        cyc();
        check("post_rst_valid", 32'(bus.disp_valid), 1);
        check("post_rst_t1",    32'(bus.disp_t1), 0);
        check("post_rst_t2",    32'(bus.disp_t2), 0);
        check("post_rst_spec",  32'(bus.disp_spec), 0);
        nofetch();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
